// File: rtl/spectrum_frame_capture_if.sv
// Stream, control/status and read-port bundle for spectrum_frame_capture.
// The master modport is the sample source / result consumer; the slave is the capture block.
interface spectrum_frame_capture_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic              start;
    logic [DATA_W-1:0] data_in;
    logic              data_valid;
    logic              data_last;
    logic              fft_shutdown;
    logic              busy;
    logic              done;
    logic              frame_err;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] peak_addr;
    logic [DATA_W-1:0] peak_val;

    modport master (
        output start, data_in, data_valid, data_last, rd_addr,
        input  fft_shutdown, busy, done, frame_err, rd_data, peak_addr, peak_val
    );

    modport slave (
        input  start, data_in, data_valid, data_last, rd_addr,
        output fft_shutdown, busy, done, frame_err, rd_data, peak_addr, peak_val
    );
endinterface

// File: rtl/spectrum_frame_capture.sv
// Multi-frame FFT magnitude capture with per-bin averaging, peak search and registered read port.
// Optional macro SPECTRUM_MAXHOLD_EN swaps averaging for per-bin max-hold.
module spectrum_frame_capture #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 8,
    parameter int AVG_LOG2  = 2,
    parameter int SKIP_BINS = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    spectrum_frame_capture_if.slave bus
);
    localparam int N  = 1 << ADDR_W;
    localparam int F  = 1 << AVG_LOG2;
    localparam int FW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
`ifdef SPECTRUM_MAXHOLD_EN
    localparam int ACC_W = DATA_W;
    localparam int SHIFT = 0;
`else
    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam int SHIFT = AVG_LOG2;
`endif
    localparam logic [ADDR_W-1:0] LAST_BIN   = {ADDR_W{1'b1}};
    localparam logic [FW-1:0]     LAST_FRAME = FW'(F - 1);
    localparam logic [ADDR_W-1:0] PEAK_LO    = ADDR_W'(SKIP_BINS);
    localparam logic [ADDR_W-1:0] PEAK_HI    = ADDR_W'(N / 2);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SYNC    = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   bin_q;
    logic [FW-1:0]       frame_q;
    logic                busy_q;
    logic                done_q;
    logic                shut_q;
    logic                err_q;
    logic [ADDR_W-1:0]   peak_addr_q;
    logic [DATA_W-1:0]   peak_val_q;
    logic [DATA_W-1:0]   rd_data_q;

    logic                wr_v_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic                wr_first_q;
    logic                wr_final_q;
    logic [DATA_W-1:0]   wr_in_q;
    logic [ACC_W-1:0]    old_q;

    logic                best_found_q;
    logic [ADDR_W-1:0]   best_addr_q;
    logic [DATA_W-1:0]   best_val_q;
    logic                best_found_d;
    logic [ADDR_W-1:0]   best_addr_d;
    logic [DATA_W-1:0]   best_val_d;

    logic [ACC_W-1:0]    wr_val_s;
    logic [DATA_W-1:0]   wr_avg_s;
    logic                at_last_s;
    logic                frm_err_s;
    logic                in_range_s;

    logic [ACC_W-1:0]    mem_q [N];

    assign at_last_s  = (bin_q == LAST_BIN);
    assign frm_err_s  = (bus.data_last != at_last_s);
    assign in_range_s = (wr_addr_q >= PEAK_LO) && (wr_addr_q < PEAK_HI);
    assign wr_avg_s   = DATA_W'(wr_val_s >> SHIFT);

    // Second half of the read-modify-write: combine the value read last beat with the new sample.
    always_comb begin
        wr_val_s = old_q;
`ifdef SPECTRUM_MAXHOLD_EN
        if (wr_first_q || (wr_in_q > old_q)) begin
            wr_val_s = wr_in_q;
        end else begin
            wr_val_s = old_q;
        end
`else
        if (wr_first_q) begin
            wr_val_s = ACC_W'(wr_in_q);
        end else begin
            wr_val_s = old_q + ACC_W'(wr_in_q);
        end
`endif
    end

    // Running peak over the final frame, fed from the write stage; strict '>' keeps the lower index on ties.
    always_comb begin
        best_found_d = best_found_q;
        best_addr_d  = best_addr_q;
        best_val_d   = best_val_q;
        if (wr_v_q && wr_final_q && in_range_s && (!best_found_q || (wr_avg_s > best_val_q))) begin
            best_found_d = 1'b1;
            best_addr_d  = wr_addr_q;
            best_val_d   = wr_avg_s;
        end else begin
            best_found_d = best_found_q;
            best_addr_d  = best_addr_q;
            best_val_d   = best_val_q;
        end
    end

    // Accumulator RAM write port; contents are intentionally left unreset.
    always_ff @(posedge clk) begin
        if (wr_v_q) begin
            mem_q[wr_addr_q] <= wr_val_s;
        end
    end

    // Capture FSM, RMW pipeline stage, peak tracking and registered read port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            bin_q        <= {ADDR_W{1'b0}};
            frame_q      <= {FW{1'b0}};
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            shut_q       <= 1'b1;
            err_q        <= 1'b0;
            peak_addr_q  <= {ADDR_W{1'b0}};
            peak_val_q   <= {DATA_W{1'b0}};
            rd_data_q    <= {DATA_W{1'b0}};
            wr_v_q       <= 1'b0;
            wr_addr_q    <= {ADDR_W{1'b0}};
            wr_first_q   <= 1'b0;
            wr_final_q   <= 1'b0;
            wr_in_q      <= {DATA_W{1'b0}};
            old_q        <= {ACC_W{1'b0}};
            best_found_q <= 1'b0;
            best_addr_q  <= {ADDR_W{1'b0}};
            best_val_q   <= {DATA_W{1'b0}};
        end else begin
            wr_v_q       <= 1'b0;
            rd_data_q    <= DATA_W'(mem_q[bus.rd_addr] >> SHIFT);
            best_found_q <= best_found_d;
            best_addr_q  <= best_addr_d;
            best_val_q   <= best_val_d;
            if (bus.start) begin
                state_q     <= SYNC;
                busy_q      <= 1'b1;
                shut_q      <= 1'b0;
                done_q      <= 1'b0;
                err_q       <= 1'b0;
                peak_addr_q <= {ADDR_W{1'b0}};
                peak_val_q  <= {DATA_W{1'b0}};
                bin_q       <= {ADDR_W{1'b0}};
                frame_q     <= {FW{1'b0}};
            end else begin
                case (state_q)
                    IDLE: begin
                        shut_q <= 1'b1;
                        busy_q <= 1'b0;
                    end
                    SYNC: begin
                        best_found_q <= 1'b0;
                        if (bus.data_valid && bus.data_last) begin
                            state_q <= CAPTURE;
                            bin_q   <= {ADDR_W{1'b0}};
                            frame_q <= {FW{1'b0}};
                        end
                    end
                    CAPTURE: begin
                        if (bus.data_valid) begin
                            // A misframed frame restarts the whole average from frame 0.
                            if (frm_err_s) begin
                                err_q   <= 1'b1;
                                state_q <= SYNC;
                                bin_q   <= {ADDR_W{1'b0}};
                                frame_q <= {FW{1'b0}};
                            end else begin
                                wr_v_q     <= 1'b1;
                                wr_addr_q  <= bin_q;
                                wr_first_q <= (frame_q == {FW{1'b0}});
                                wr_final_q <= (frame_q == LAST_FRAME);
                                wr_in_q    <= bus.data_in;
                                old_q      <= mem_q[bin_q];
                                bin_q      <= bin_q + ADDR_W'(1);
                                if (at_last_s) begin
                                    if (frame_q == LAST_FRAME) begin
                                        state_q     <= DONE;
                                        busy_q      <= 1'b0;
                                        done_q      <= 1'b1;
                                        shut_q      <= 1'b1;
                                        peak_addr_q <= best_addr_d;
                                        peak_val_q  <= best_val_d;
                                    end else begin
                                        frame_q <= frame_q + FW'(1);
                                    end
                                end
                            end
                        end
                    end
                    DONE: begin
                        done_q <= 1'b1;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.fft_shutdown = shut_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.frame_err    = err_q;
    assign bus.rd_data      = rd_data_q;
    assign bus.peak_addr    = peak_addr_q;
    assign bus.peak_val     = peak_val_q;

endmodule

// File: tb/tb_spectrum_frame_capture.sv
// Directed bench for spectrum_frame_capture with hand-computed expected values.
module tb_spectrum_frame_capture;
    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 8;
    localparam int AVG_LOG2  = 2;
    localparam int SKIP_BINS = 2;
    localparam int N         = 256;
`ifdef SPECTRUM_MAXHOLD_EN
    localparam int EXP_BIN10 = 160;
    localparam int EXP_BIN5  = 90;
`else
    localparam int EXP_BIN10 = 130;
    localparam int EXP_BIN5  = 42;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    spectrum_frame_capture_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    spectrum_frame_capture #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .AVG_LOG2(AVG_LOG2), .SKIP_BINS(SKIP_BINS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Per-bin stimulus patterns: 0 ramp, 1 bin10 sweep + DC, 2 tie, 3 bin5 sequence, other junk.
    function automatic logic [15:0] bin_val(input int mode, input int fr, input int b);
        case (mode)
            0: return 16'(b);
            1: begin
                if (b == 10) return 16'(100 + 20 * fr);
                else if (b < 2) return 16'd1000;
                else return 16'd0;
            end
            2: return (b == 20 || b == 90) ? 16'd50 : 16'd0;
            3: begin
                if (b != 5) return 16'd0;
                case (fr)
                    0: return 16'd30;
                    1: return 16'd90;
                    2: return 16'd10;
                    default: return 16'd40;
                endcase
            end
            default: return 16'hFFFF;
        endcase
    endfunction

    task automatic beat(input logic [15:0] d, input logic last, input logic strt);
        @(negedge clk);
        bus.data_in    = d;
        bus.data_valid = 1'b1;
        bus.data_last  = last;
        bus.start      = strt;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        bus.data_valid = 1'b0;
        bus.data_last  = 1'b1;
        bus.data_in    = 16'hFFFF;
        bus.start      = 1'b0;
    endtask

    task automatic send_frame(input int mode, input int fr, input int nbeats,
                              input bit gaps, input bit start_last);
        for (int b = 0; b < nbeats; b++) begin
            if (gaps && (b % 16 == 15)) idle_cycle();
            beat(bin_val(mode, fr, b), (b == nbeats - 1), (start_last && (b == nbeats - 1)));
        end
        idle_cycle();
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start      = 1'b1;
        bus.data_valid = 1'b0;
        @(negedge clk);
        bus.start      = 1'b0;
    endtask

    task automatic read_chk(input string tag, input int addr, input int exp);
        @(negedge clk);
        bus.rd_addr = 8'(addr);
        @(negedge clk);
        check_eq(tag, 32'(bus.rd_data), 32'(exp));
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.data_in    = 16'd0;
        bus.data_valid = 1'b0;
        bus.data_last  = 1'b0;
        bus.rd_addr    = 8'd0;
        repeat (3) @(negedge clk);
        check_eq("rst_shutdown",  32'(bus.fft_shutdown), 32'd1);
        check_eq("rst_busy",      32'(bus.busy),         32'd0);
        check_eq("rst_done",      32'(bus.done),         32'd0);
        check_eq("rst_frame_err", 32'(bus.frame_err),    32'd0);
        check_eq("rst_rd_data",   32'(bus.rd_data),      32'd0);
        check_eq("rst_peak_addr", 32'(bus.peak_addr),    32'd0);
        check_eq("rst_peak_val",  32'(bus.peak_val),     32'd0);
        rst = 1'b0;
        idle_cycle();
        check_eq("idle_ignores_valid", 32'(bus.busy), 32'd0);

        // Ramp frames after a junk partial frame.
        pulse_start();
        check_eq("t1_busy",     32'(bus.busy),         32'd1);
        check_eq("t1_shutdown", 32'(bus.fft_shutdown), 32'd0);
        send_frame(4, 0, 50, 1'b0, 1'b0);
        for (int f = 0; f < 3; f++) send_frame(0, f, N, 1'b0, 1'b0);
        check_eq("t1_done_early", 32'(bus.done), 32'd0);
        check_eq("t1_busy_early", 32'(bus.busy), 32'd1);
        send_frame(0, 3, N, 1'b0, 1'b0);
        check_eq("t1_done",      32'(bus.done),         32'd1);
        check_eq("t1_busy_end",  32'(bus.busy),         32'd0);
        check_eq("t1_shut_end",  32'(bus.fft_shutdown), 32'd1);
        check_eq("t1_err",       32'(bus.frame_err),    32'd0);
        read_chk("t1_rd37", 37, 37);
        read_chk("t1_rd255", 255, 255);
        check_eq("t1_peak_addr", 32'(bus.peak_addr), 32'd127);
        check_eq("t1_peak_val",  32'(bus.peak_val),  32'd127);
        send_frame(4, 0, N, 1'b0, 1'b0);
        check_eq("t1_done_hold", 32'(bus.done), 32'd1);
        read_chk("t1_rd37_hold", 37, 37);

        // Averaged single bin with large DC bins excluded from peak search.
        pulse_start();
        check_eq("t2_done_clr",  32'(bus.done),      32'd0);
        check_eq("t2_peak_clr",  32'(bus.peak_addr), 32'd0);
        check_eq("t2_pval_clr",  32'(bus.peak_val),  32'd0);
        send_frame(4, 0, 1, 1'b0, 1'b0);
        for (int f = 0; f < 4; f++) send_frame(1, f, N, 1'b0, 1'b0);
        check_eq("t2_done", 32'(bus.done), 32'd1);
        read_chk("t2_rd10", 10, EXP_BIN10);
        read_chk("t2_rd0", 0, 1000);
        check_eq("t2_peak_addr", 32'(bus.peak_addr), 32'd10);
        check_eq("t2_peak_val",  32'(bus.peak_val),  32'(EXP_BIN10));

        // Tied maxima with idle gaps in the stream.
        pulse_start();
        send_frame(4, 0, 1, 1'b0, 1'b0);
        for (int f = 0; f < 4; f++) send_frame(2, f, N, 1'b1, 1'b0);
        check_eq("t3_done",      32'(bus.done),      32'd1);
        check_eq("t3_peak_addr", 32'(bus.peak_addr), 32'd20);
        check_eq("t3_peak_val",  32'(bus.peak_val),  32'd50);
        read_chk("t3_rd90", 90, 50);

        // Framing error: early data_last in frame 2.
        pulse_start();
        send_frame(4, 0, 1, 1'b0, 1'b0);
        send_frame(0, 0, N, 1'b0, 1'b0);
        send_frame(0, 1, N, 1'b0, 1'b0);
        send_frame(4, 2, 201, 1'b0, 1'b0);
        check_eq("t4_err",  32'(bus.frame_err), 32'd1);
        check_eq("t4_busy", 32'(bus.busy),      32'd1);
        check_eq("t4_done", 32'(bus.done),      32'd0);
        send_frame(4, 0, N, 1'b0, 1'b0);
        for (int f = 0; f < 4; f++) send_frame(0, f, N, 1'b0, 1'b0);
        check_eq("t4_done_end", 32'(bus.done),      32'd1);
        check_eq("t4_err_held", 32'(bus.frame_err), 32'd1);
        read_chk("t4_rd37", 37, 37);
        read_chk("t4_rd150", 150, 150);
        check_eq("t4_peak_addr", 32'(bus.peak_addr), 32'd127);

        // Restart in the middle of frame 1.
        pulse_start();
        check_eq("t5_err_clr", 32'(bus.frame_err), 32'd0);
        send_frame(4, 0, 1, 1'b0, 1'b0);
        send_frame(4, 0, N, 1'b0, 1'b0);
        for (int b = 0; b < 100; b++) beat(16'hFFFF, 1'b0, 1'b0);
        pulse_start();
        check_eq("t5_busy",     32'(bus.busy),         32'd1);
        check_eq("t5_shutdown", 32'(bus.fft_shutdown), 32'd0);
        check_eq("t5_done",     32'(bus.done),         32'd0);
        send_frame(4, 0, 1, 1'b0, 1'b0);
        for (int f = 0; f < 4; f++) send_frame(3, f, N, 1'b0, 1'b0);
        check_eq("t5_done_end", 32'(bus.done), 32'd1);
        read_chk("t5_rd5", 5, EXP_BIN5);
        check_eq("t5_peak_addr", 32'(bus.peak_addr), 32'd5);
        check_eq("t5_peak_val",  32'(bus.peak_val),  32'(EXP_BIN5));

        // start coincident with the final beat wins over completion.
        pulse_start();
        send_frame(4, 0, 1, 1'b0, 1'b0);
        for (int f = 0; f < 3; f++) send_frame(0, f, N, 1'b0, 1'b0);
        send_frame(0, 3, N, 1'b0, 1'b1);
        check_eq("t6_done",      32'(bus.done),         32'd0);
        check_eq("t6_busy",      32'(bus.busy),         32'd1);
        check_eq("t6_shutdown",  32'(bus.fft_shutdown), 32'd0);
        check_eq("t6_peak_addr", 32'(bus.peak_addr),    32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
